// File: rtl/rx_header_sync_if.sv
// Stream bundle for rx_header_sync: I/Q samples in, demapped payload symbols out, plus status.
// The master modport is the environment side; the slave modport is the synchronizer side.
interface rx_header_sync_if #(
  parameter int DATA_W = 12
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_i;
  logic [DATA_W-1:0] in_q;
  logic              in_ready;
  logic              out_valid;
  logic [1:0]        out_data;
  logic              out_last;
  logic              out_ready;
  logic              locked;
  logic [15:0]       frame_cnt;
  logic [15:0]       hdr_err_cnt;

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_data, out_last, locked, frame_cnt, hdr_err_cnt
  );

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output in_ready, out_valid, out_data, out_last, locked, frame_cnt, hdr_err_cnt
  );
endinterface

// File: rtl/rx_header_sync.sv
// QPSK header search, then header strip and streaming of a fixed-length payload.
// Latency: lock 1 cycle after the matching symbol; each payload symbol appears 1 cycle after acceptance.
// Backpressure: always ready while searching; in payload, ready = out_ready | ~out_valid. RX_SYNC_STATS_EN adds counters.
module rx_header_sync #(
  parameter int                        DATA_W         = 12,
  parameter int                        HEADER_LEN     = 16,
  parameter logic [2*HEADER_LEN-1:0]   HEADER_PATTERN = 32'hF35A_0C96,
  parameter int                        PAYLOAD_LEN    = 256,
  parameter int                        MAX_ERR        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rx_header_sync_if.slave   bus
);

  localparam int SR_W = 2 * HEADER_LEN;
  localparam int FW   = $clog2(HEADER_LEN + 1);
  localparam int PW   = $clog2(PAYLOAD_LEN);

  localparam logic [FW-1:0] FILL_FULL = FW'(HEADER_LEN);
  localparam logic [FW-1:0] FILL_MIN  = FW'(HEADER_LEN - 1);
  localparam logic [FW-1:0] ERR_MAX   = FW'(MAX_ERR);
  localparam logic [PW-1:0] LAST_IDX  = PW'(PAYLOAD_LEN - 1);

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   shreg;
  logic [FW-1:0]     fill;
  logic [PW-1:0]     pcnt;
  logic              out_valid_q;
  logic [1:0]        out_data_q;
  logic              out_last_q;
  logic              locked_q;

  logic [1:0]        sym;
  logic [SR_W-1:0]   cand;
  logic [FW-1:0]     n_err;
  logic              in_acc;
  logic              out_acc;
  logic              match;
  logic              last_in;

  function automatic logic [FW-1:0] count_err(input logic [SR_W-1:0] c);
    logic [FW-1:0] n;
    n = '0;
    for (int k = 0; k < HEADER_LEN; k++) begin
      if (c[2*k +: 2] != HEADER_PATTERN[2*k +: 2]) n = n + FW'(1);
    end
    return n;
  endfunction

  assign bus.in_ready = (state == SEARCH) | bus.out_ready | ~out_valid_q;

  always_comb begin
    sym     = {bus.in_i[DATA_W-1], bus.in_q[DATA_W-1]};
    cand    = {shreg[SR_W-3:0], sym};
    n_err   = count_err(cand);
    in_acc  = bus.in_valid & bus.in_ready;
    out_acc = out_valid_q & bus.out_ready;
    // Fill guard keeps stale reset zeros in the register from completing a header.
    match   = in_acc && (state == SEARCH) && (fill >= FILL_MIN) && (n_err <= ERR_MAX);
    last_in = (pcnt == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      shreg       <= '0;
      fill        <= '0;
      pcnt        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 2'b00;
      out_last_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      if (out_acc) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      case (state)
        SEARCH: begin
          if (in_acc) begin
            if (match) begin
              state    <= PAYLOAD;
              locked_q <= 1'b1;
              shreg    <= '0;
              fill     <= '0;
              pcnt     <= '0;
            end else begin
              shreg <= cand;
              if (fill != FILL_FULL) fill <= fill + FW'(1);
            end
          end
        end
        PAYLOAD: begin
          // A load in the same cycle as a drain overrides the clear above.
          if (in_acc) begin
            out_data_q  <= sym;
            out_valid_q <= 1'b1;
            out_last_q  <= last_in;
            if (last_in) begin
              state    <= SEARCH;
              locked_q <= 1'b0;
              pcnt     <= '0;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.locked    = locked_q;

`ifdef RX_SYNC_STATS_EN
  logic [15:0] frame_q;
  logic [15:0] hdr_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      hdr_err_q <= '0;
    end else begin
      if (out_acc && out_last_q) frame_q <= frame_q + 16'd1;
      if (match && (n_err != '0)) hdr_err_q <= hdr_err_q + 16'd1;
    end
  end

  assign bus.frame_cnt   = frame_q;
  assign bus.hdr_err_cnt = hdr_err_q;
`else
  assign bus.frame_cnt   = '0;
  assign bus.hdr_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_header_sync.sv
// Scoreboard bench for rx_header_sync: a reference model predicts payload symbols as samples are accepted.
// A negedge monitor pops and compares each output handshake and checks stall stability.
module tb_rx_header_sync;

  localparam int          DATA_W  = 12;
  localparam int          HL      = 16;
  localparam int          PL      = 256;
  localparam logic [31:0] PATTERN = 32'hF35A_0C96;
`ifdef RX_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_header_sync_if #(.DATA_W(DATA_W)) bus ();

  rx_header_sync #(
    .DATA_W(DATA_W), .HEADER_LEN(HL), .HEADER_PATTERN(PATTERN),
    .PAYLOAD_LEN(PL), .MAX_ERR(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: search history, remaining payload count, expected outputs.
  logic [2:0] exp_q[$];
  logic [1:0] hist[$];
  int mdl_pay = 0;
  int exp_frames = 0;
  int exp_hdr_err = 0;

  function automatic logic [1:0] hdr_sym(input int k);
    logic [31:0] p;
    p = PATTERN;
    return p[31-2*k -: 2];
  endfunction

  function automatic int hist_errs();
    int e;
    int n;
    e = 0;
    n = hist.size();
    for (int k = 0; k < HL; k++) if (hist[n-HL+k] != hdr_sym(k)) e++;
    return e;
  endfunction

  task automatic mdl_step(input logic [1:0] s);
    if (mdl_pay > 0) begin
      exp_q.push_back({mdl_pay == 1, s});
      if (mdl_pay == 1) exp_frames++;
      mdl_pay--;
    end else begin
      hist.push_back(s);
      if (hist.size() >= HL) begin
        int e;
        e = hist_errs();
        if (e <= 1) begin
          mdl_pay = PL;
          hist.delete();
          if (e > 0) exp_hdr_err++;
        end
      end
    end
  endtask

  // Output-ready pattern generator: 0 = always, 1 = 1,0,0,1 cycle, 2 = stall each last symbol 3 cycles.
  int or_mode = 0;
  int cyc = 0;
  int stall_n = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    case (or_mode)
      1: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: begin
        if (bus.out_valid && bus.out_last && stall_n < 3) begin
          bus.out_ready = 1'b0;
          stall_n++;
        end else begin
          bus.out_ready = 1'b1;
          if (!bus.out_last) stall_n = 0;
        end
      end
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor
  int n_out = 0;
  int lock_cyc = 0;
  logic stall_prev = 1'b0;
  logic [2:0] prev_out;
  logic [2:0] exp_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.locked) lock_cyc++;
      if (stall_prev) check_eq("hold_stable", {bus.out_last, bus.out_data}, prev_out);
      if (bus.out_valid && !bus.out_ready) begin
        if (bus.locked) check_eq("in_ready_bp", bus.in_ready, 0);
        stall_prev = 1'b1;
        prev_out = {bus.out_last, bus.out_data};
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check_eq("unexpected_out", 1, 0);
        else begin
          exp_e = exp_q.pop_front();
          check_eq("payload_sym", {bus.out_last, bus.out_data}, exp_e);
        end
      end
    end
  end

  task automatic send(input logic [1:0] s);
    int t;
    logic r;
    logic [DATA_W-1:0] mi, mq;
    t = 0;
    mi = DATA_W'($urandom_range(0, 2047));
    mq = DATA_W'($urandom_range(0, 2047));
    bus.in_valid = 1'b1;
    bus.in_i = s[1] ? ~mi : mi;
    bus.in_q = s[0] ? ~mq : mq;
    forever begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        mdl_step(s);
        break;
      end
      t++;
      if (t > 1000) begin
        check_eq("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_header(input int f1, input int f2);
    logic [1:0] s;
    for (int k = 0; k < HL; k++) begin
      s = hdr_sym(k);
      if (k == f1 || k == f2) s = s ^ 2'b01;
      send(s);
    end
  endtask

  task automatic send_payload(input int n);
    for (int k = 0; k < n; k++) send(2'(k % 4));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("drain_done", (exp_q.size() == 0) && !bus.out_valid, 1);
  endtask

  task automatic check_stats();
    check_eq("frame_cnt", bus.frame_cnt, STATS ? exp_frames : 0);
    check_eq("hdr_err_cnt", bus.hdr_err_cnt, STATS ? exp_hdr_err : 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    check_eq("rst_locked", bus.locked, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    hist.delete();
    mdl_pay = 0;
    exp_frames = 0;
    exp_hdr_err = 0;
    check_stats();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int b_out;
  int b_lock;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Header then payload
    b_out = n_out;
    b_lock = lock_cyc;
    repeat (5) send(2'($urandom_range(0, 3)));
    send_header(-1, -1);
    send_payload(PL);
    idle(1);
    drain();
    check_eq("t1_outputs", n_out - b_out, PL);
    check_eq("t1_lock_cycles", lock_cyc - b_lock, PL);
    check_stats();

    // One tolerated header error
    b_out = n_out;
    send_header(7, -1);
    send_payload(PL);
    idle(1);
    drain();
    check_eq("t2_outputs", n_out - b_out, PL);
    check_stats();

    // Two header errors: no lock
    b_out = n_out;
    b_lock = lock_cyc;
    send_header(3, 9);
    idle(4);
    check_eq("t2b_locked", bus.locked, 0);
    check_eq("t2b_lock_cycles", lock_cyc - b_lock, 0);
    check_eq("t2b_outputs", n_out - b_out, 0);

    // Fill guard, then payload under backpressure
    do_reset();
    b_lock = lock_cyc;
    for (int k = 1; k < HL; k++) send(hdr_sym(k));
    idle(2);
    check_eq("fill_guard_lock", lock_cyc - b_lock, 0);
    or_mode = 1;
    send_header(-1, -1);
    check_eq("lock_after_hdr", bus.locked, 1);
    b_out = n_out;
    send_payload(PL);
    idle(1);
    drain();
    check_eq("bp_outputs", n_out - b_out, PL);
    or_mode = 0;

    // Back-to-back frames, last symbol stalled
    do_reset();
    or_mode = 2;
    b_out = n_out;
    send_header(-1, -1);
    send_payload(PL);
    send_header(-1, -1);
    send_payload(PL);
    idle(1);
    drain();
    check_eq("b2b_outputs", n_out - b_out, 2 * PL);
    check_eq("b2b_frames_model", exp_frames, 2);
    check_stats();
    or_mode = 0;

    // Reset mid-payload
    send_header(-1, -1);
    send_payload(100);
    do_reset();
    b_out = n_out;
    send_payload(20);
    idle(2);
    check_eq("post_rst_outputs", n_out - b_out, 0);
    check_eq("post_rst_locked", bus.locked, 0);
    send_header(-1, -1);
    send_payload(PL);
    idle(1);
    drain();
    check_eq("relock_outputs", n_out - b_out, PL);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rx_header_sync.md
# rx_header_sync

Receive-side frame synchronizer for the QPSK link. It takes matched-filtered I/Q samples, makes hard QPSK decisions, and searches for the known header symbol sequence. Once a header is found, it strips the header and streams the fixed-length payload as 2-bit symbols, marking the last symbol of each frame. It sits between the receive FIR and the 2-to-1 stream resizer feeding the BCH decoder, mirroring the header inserter on the transmit path.

## Interface
Parameters:
- DATA_W, 12, sample width per I/Q rail (two's complement)
- HEADER_LEN, 16, header length in symbols
- HEADER_PATTERN, 32'hF35A_0C96, 2*HEADER_LEN bits; MSB pair is the first transmitted symbol; each pair is {I bit, Q bit}
- PAYLOAD_LEN, 256, payload symbols per frame (≥ 2)
- MAX_ERR, 1, maximum number of mismatched header symbols tolerated

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  AXIS sample valid
- in_i  in  DATA_W  I sample
- in_q  in  DATA_W  Q sample
- in_ready  out  1  AXIS sample ready
- out_valid  out  1  payload symbol valid
- out_data  out  2  {I bit, Q bit}
- out_last  out  1  high with the final payload symbol of a frame
- out_ready  in  1  downstream ready
- locked  out  1  high while in the PAYLOAD state
- frame_cnt  out  16  frames completed (see Configuration)
- hdr_err_cnt  out  16  headers accepted with ≥1 symbol error (see Configuration)

## Operation
- Demap: I bit = in_i[DATA_W-1] and Q bit = in_q[DATA_W-1]. A negative sample gives 1. A zero sample gives 0.
- A transfer occurs on a cycle where in_valid and in_ready are both high. Out-handshake follows the same rule.
- SEARCH state:
  - in_ready = 1.
  - Each accepted symbol shifts into a 2*HEADER_LEN-bit register, with the newest symbol in the LSB pair.
  - A saturating fill counter (0..HEADER_LEN) counts accepted symbols.
  - Candidate = register shifted with the current symbol.
  - Match when both hold: (fill counter ≥ HEADER_LEN-1 before the shift) AND (the number of symbol pairs differing from HEADER_PATTERN ≤ MAX_ERR).
  - On a match, go to PAYLOAD, set the payload counter to 0, and clear the shift register and fill counter.
  - No output is produced in SEARCH.
- PAYLOAD state:
  - in_ready = out_ready | ~out_valid, using a single output register.
  - Each accepted sample loads out_data with its demapped symbol and sets out_valid.
  - out_last is set when payload counter = PAYLOAD_LEN-1.
  - The payload counter increments on each accepted sample.
  - After the PAYLOAD_LEN-th accepted sample, return to SEARCH.
- out_valid clears on an out-handshake with no new load. A simultaneous handshake and load keeps out_valid at 1 with the new data.
- While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Header detection never overlaps a payload; payload samples are never searched.
- Reset, including mid-frame: state = SEARCH; shift register, fill counter, and payload counter = 0; out_valid = out_last = locked = 0; out_data = 0; counters = 0. in_ready = 1 from the first cycle after release.

## Timing
- Match evaluation is combinational on the accepting cycle N. locked = 1 from N+1.
- The first payload sample can be accepted at N+1.
- PAYLOAD latency: out_valid is asserted the cycle after the sample is accepted.
- Back-to-back frames: the final payload sample returns the block to SEARCH on the next cycle. The next header can begin at that cycle. The last output symbol may still be draining under backpressure; this does not block SEARCH.
- Throughput: 1 sample per cycle in both states when out_ready = 1.

## Configuration
- RX_SYNC_STATS_EN defined:
  - frame_cnt increments (wrapping at 16 bits) on the handshake of each out_last symbol.
  - hdr_err_cnt increments (wrapping) on each match with 1..MAX_ERR mismatches.
- Not defined: the counter logic is removed and frame_cnt and hdr_err_cnt are tied to 0. All other behaviour is identical.

## Test plan
- Header then payload: feed 5 random symbols, the exact HEADER_PATTERN, then 256 payload symbols 0,1,2,3 repeating, with out_ready=1. Required: exactly 256 outputs with the same sequence, out_last only on the 256th, and locked high for exactly 256 cycles. With stats enabled, frame_cnt = 1 and hdr_err_cnt = 0.
- Tolerated error: the header has symbol 7 flipped. Required: lock and full payload; hdr_err_cnt = 1. With 2 symbols flipped: no lock, no outputs.
- Backpressure: toggle out_ready 1,0,0,1 during the payload. Required: no symbol lost or duplicated, data stable while stalled, and in_ready low when out_valid=1 and out_ready=0.
- Fill guard: immediately after reset, feed 15 symbols equal to the last 15 header symbols. Required: no lock. After the 16-symbol pattern: lock.
- Back-to-back: two frames with no gap, last output stalled 3 cycles. Required: the second header is detected, 512 outputs total, and frame_cnt = 2.
- Reset mid-payload: assert rst_n=0 at payload symbol 100. Required: all outputs 0 immediately and locked = 0. Subsequent payload-like samples are not output until a new header arrives.
